// File: rtl/dice_roll_sequencer.sv
// dice_roll_sequencer
// -------------------
// Initiator for a dice roller. Accepts one command (die type, roll count),
// issues the rolls back-to-back on die_select/roll, captures each
// rolled_number, range-checks it, and returns sum/min/max/error through a
// valid/ready result handshake.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. cmd_ready is high only in IDLE. result_valid is high only in
// DONE, and result_* are stable while result_valid=1 and result_ready=0.
//
// Timing: roll is high for one cycle. rolled_number is sampled ROLL_LATENCY
// cycles later (ROLL -> WAIT x (ROLL_LATENCY-1) -> CAPTURE). Rolls are spaced
// ROLL_LATENCY+1 cycles apart.
//
// Optional feature: define DICE_SEQ_DROP_LOWEST_EN to add cmd_drop_lowest.
// When it is set on a command with count>=2, result_sum excludes the lowest
// roll. result_min and result_max still cover every roll.
//
// Ports:
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready    command handshake; cmd_die (0=d4,1=d6,2=d8,3=d20),
//                      cmd_count (0..15)
//   cmd_drop_lowest    (only with DICE_SEQ_DROP_LOWEST_EN)
//   die_select, roll   to roller; rolled_number from roller
//   result_valid/ready result handshake; result_sum/min/max/error
//   state              debug view of the FSM state (IDLE=0 .. DONE=4)
module dice_roll_sequencer #(
  parameter int ROLL_LATENCY = 2,
  parameter int SUM_W        = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_die,
  input  logic [3:0]       cmd_count,
`ifdef DICE_SEQ_DROP_LOWEST_EN
  input  logic             cmd_drop_lowest,
`endif
  output logic [1:0]       die_select,
  output logic             roll,
  input  logic [7:0]       rolled_number,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [SUM_W-1:0] result_sum,
  output logic [7:0]       result_min,
  output logic [7:0]       result_max,
  output logic             result_error,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ROLL    = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int LAT_W = (ROLL_LATENCY > 2) ? $clog2(ROLL_LATENCY) : 1;

  state_t             state_q, state_d;
  logic [LAT_W-1:0]   lat_cnt;
  logic [3:0]         remaining;
  logic [SUM_W-1:0]   acc_sum;
  logic [7:0]         acc_min;
  logic [7:0]         acc_max;
  logic               acc_err;
  logic               drop_q;
  logic               drop_req;

  logic [7:0]         die_limit;
  logic               out_of_range;
  logic [SUM_W-1:0]   sum_new;
  logic [7:0]         min_new;
  logic [7:0]         max_new;
  logic               err_new;
  logic               accept;

  assign state        = state_q;
  assign accept       = (state_q == IDLE) && cmd_valid;

`ifdef DICE_SEQ_DROP_LOWEST_EN
  assign drop_req     = cmd_drop_lowest && (cmd_count >= 4'd2);
`else
  assign drop_req     = 1'b0;
`endif

  // Upper bound of the currently selected die.
  always_comb begin
    die_limit = 8'd4;
    case (die_select)
      2'd0:    die_limit = 8'd4;
      2'd1:    die_limit = 8'd6;
      2'd2:    die_limit = 8'd8;
      default: die_limit = 8'd20;
    endcase
  end

  // Accumulator values including the roll being captured this cycle.
  // Out-of-range values still contribute to sum/min/max.
  assign out_of_range = (rolled_number == 8'd0) || (rolled_number > die_limit);
  assign sum_new      = acc_sum + SUM_W'(rolled_number);
  assign min_new      = (rolled_number < acc_min) ? rolled_number : acc_min;
  assign max_new      = (rolled_number > acc_max) ? rolled_number : acc_max;
  assign err_new      = acc_err | out_of_range;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    cmd_ready    = 1'b0;
    roll         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = (cmd_count == 4'd0) ? DONE : ROLL;
      end
      ROLL: begin
        roll    = 1'b1;
        // With a one-cycle roller there is no wait stage at all.
        state_d = (ROLL_LATENCY <= 1) ? CAPTURE : WAIT;
      end
      WAIT: begin
        if (lat_cnt == '0) state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = (remaining == 4'd1) ? DONE : ROLL;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      die_select   <= 2'd0;
      remaining    <= 4'd0;
      lat_cnt      <= '0;
      acc_sum      <= '0;
      acc_min      <= 8'hFF;
      acc_max      <= 8'd0;
      acc_err      <= 1'b0;
      drop_q       <= 1'b0;
      result_sum   <= '0;
      result_min   <= 8'd0;
      result_max   <= 8'd0;
      result_error <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            die_select <= cmd_die;
            remaining  <= cmd_count;
            acc_sum    <= '0;
            acc_min    <= 8'hFF;
            acc_max    <= 8'd0;
            acc_err    <= 1'b0;
            drop_q     <= drop_req;
            // An empty command completes immediately with an all-zero result.
            if (cmd_count == 4'd0) begin
              result_sum   <= '0;
              result_min   <= 8'd0;
              result_max   <= 8'd0;
              result_error <= 1'b0;
            end
          end
        end
        ROLL: begin
          // WAIT exits when the counter reads zero, so load (cycles - 1).
          lat_cnt <= LAT_W'(ROLL_LATENCY - 2);
        end
        WAIT: begin
          if (lat_cnt != '0) lat_cnt <= lat_cnt - 1'b1;
        end
        CAPTURE: begin
          acc_sum   <= sum_new;
          acc_min   <= min_new;
          acc_max   <= max_new;
          acc_err   <= err_new;
          remaining <= remaining - 4'd1;
          // Publish on the last roll; results then hold until the next
          // command completes, independent of the result handshake.
          if (remaining == 4'd1) begin
            result_sum   <= drop_q ? (sum_new - SUM_W'(min_new)) : sum_new;
            result_min   <= min_new;
            result_max   <= max_new;
            result_error <= err_new;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
